// File: rtl/age_arb.sv
// age_arb: age-based arbiter; the oldest active requester wins a one-hot grant held under valid/ready.
// Optional macro AGE_ARB_LOCK_EN adds a `lock` input that keeps the grant on the same lane.
`ifndef HIGH
`define HIGH 1'b1
`endif

module sel_minmax #(
    parameter int N   = 2,
    parameter int W   = 1,
    parameter bit MAX = 1'b1
) (
    input  logic [N-1:0][W-1:0]  key,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    logic [W-1:0] best;

    // Strict compare keeps the lower index on equal keys.
    always_comb begin
        idx  = '0;
        best = key[0];
        for (int i = 1; i < N; i++) begin
            if (MAX ? (key[i] > best) : (key[i] < best)) begin
                idx  = IW'(i);
                best = key[i];
            end
        end
    end
endmodule

module age_arb #(
    parameter int   REQ = 8,
    parameter int   AGE = 4,
    parameter logic ACT = `HIGH
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic [REQ-1:0]          req,
    input  logic                    ready,
`ifdef AGE_ARB_LOCK_EN
    input  logic                    lock,
`endif
    output logic [REQ-1:0]          grant,
    output logic [$clog2(REQ)-1:0]  grant_idx,
    output logic                    grant_valid
);
    localparam int         IDX_W   = $clog2(REQ);
    localparam int         KEY_W   = AGE + 1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]                state;
    logic [REQ-1:0][AGE-1:0]   age;
    logic [REQ-1:0][KEY_W-1:0] key;
    logic [REQ-1:0]            req_act;
    logic [REQ-1:0]            cur_oh;
    logic [REQ-1:0]            cand;
    logic [IDX_W-1:0]          win_idx;
    logic                      hs;
    logic                      win_ok;
    logic                      lock_i;
    logic                      relock;

`ifdef AGE_ARB_LOCK_EN
    assign lock_i = lock;
`else
    assign lock_i = 1'b0;
`endif

    function automatic logic [AGE-1:0] sat_inc(input logic [AGE-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    function automatic logic [REQ-1:0] decode(input logic [IDX_W-1:0] i);
        logic [REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign req_act     = ACT ? req : ~req;
    assign grant_valid = (state == S_GRANT);
    assign hs          = grant_valid && ready;
    assign cur_oh      = grant_valid ? decode(grant_idx) : '0;
    // The lane completing its handshake is masked out of this cycle's pick.
    assign cand        = req_act & ~(hs ? cur_oh : '0);
    assign win_ok      = |cand;
    assign relock      = hs && lock_i && (|(req_act & cur_oh));

    always_comb begin
        for (int i = 0; i < REQ; i++) begin
            key[i] = {cand[i], age[i]};
        end
    end

    sel_minmax #(
        .N   (REQ),
        .W   (KEY_W),
        .MAX (1'b1)
    ) u_sel (
        .key (key),
        .idx (win_idx)
    );

    // Granted lane holds its age until its handshake clears it.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            age <= '0;
        end else begin
            for (int i = 0; i < REQ; i++) begin
                if (!req_act[i] || (cur_oh[i] && hs)) begin
                    age[i] <= '0;
                end else if (!cur_oh[i]) begin
                    age[i] <= sat_inc(age[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= S_IDLE;
            grant_idx <= '0;
            grant     <= {REQ{~ACT}};
        end else if (state == S_IDLE || hs) begin
            if (relock) begin
                state <= S_GRANT;
            end else if (win_ok) begin
                state     <= S_GRANT;
                grant_idx <= win_idx;
                grant     <= ACT ? decode(win_idx) : ~decode(win_idx);
            end else begin
                state     <= S_IDLE;
                grant_idx <= '0;
                grant     <= {REQ{~ACT}};
            end
        end
    end
endmodule

// File: tb/tb_age_arb.sv
// Self-checking bench for age_arb (REQ=4, AGE=4, active-high): vector table, corner sequences, random vs model.
`timescale 1ns/1ps

module tb_age_arb;
    localparam int AGE_MAX = 15;

    logic       clk;
    logic       reset_;
    logic [3:0] req;
    logic       ready;
    logic       lock;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int n_assert = 0;
    int n_fail   = 0;

    age_arb #(.REQ(4), .AGE(4), .ACT(1'b1)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .req         (req),
        .ready       (ready),
`ifdef AGE_ARB_LOCK_EN
        .lock        (lock),
`endif
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Reference model: per-lane ages as plain integers, winner = oldest requester.
    int m_age[4];
    bit m_valid;
    int m_idx;

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input bit rdy, input bit lk);
        int nxt[4];
        int best;
        bit hs;
        hs = m_valid && rdy;
        for (int i = 0; i < 4; i++) begin
            if (!r[i])                        nxt[i] = 0;
            else if (m_valid && i == m_idx)   nxt[i] = hs ? 0 : m_age[i];
            else                              nxt[i] = (m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1;
        end
        if (!m_valid || hs) begin
            if (!(hs && lk && r[m_idx])) begin
                best = -1;
                for (int i = 0; i < 4; i++) begin
                    if (r[i] && !(hs && i == m_idx) && (best < 0 || m_age[i] > m_age[best]))
                        best = i;
                end
                m_valid = (best >= 0);
                m_idx   = m_valid ? best : 0;
            end
        end
        for (int i = 0; i < 4; i++) m_age[i] = nxt[i];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        req    = '0;
        ready  = 1'b0;
        lock   = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic [3:0] r, input bit rdy, input bit lk);
        req   = r;
        ready = rdy;
        lock  = lk;
        @(posedge clk);
        #1;
        model_step(r, rdy, lk);
    endtask

    task automatic chk_grant(input string nm, input logic [3:0] g, input bit v, input int idx);
        chk({nm, "_grant"}, 32'(grant), 32'(g));
        chk({nm, "_valid"}, 32'(grant_valid), 32'(v));
        if (v) chk({nm, "_idx"}, 32'(grant_idx), 32'(idx));
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        bit         rdy;
        logic [3:0] g;
        bit         v;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int exp_idx;
        logic [3:0] eg;
        reset_ = 1'b0;
        req    = '0;
        ready  = 1'b0;
        lock   = 1'b0;
        model_reset();

        // Fair rotation, single requester, hold without preemption, late drop of req.
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[6]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1};
        tbl[7]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1};
        tbl[9]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[10] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[11] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1};
        tbl[12] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1};
        tbl[13] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1};
        tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[15] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[16] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1};
        tbl[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0};

        for (int k = 0; k < 18; k++) begin
            if (tbl[k].rst) do_reset();
            step(tbl[k].req, tbl[k].rdy, 1'b0);
            exp_idx = 0;
            eg = tbl[k].g;
            for (int j = 0; j < 4; j++) if (eg[j]) exp_idx = j;
            chk_grant($sformatf("tbl%0d", k), tbl[k].g, tbl[k].v, exp_idx);
        end

        // Asynchronous reset between edges drops the in-flight grant.
        do_reset();
        step(4'b1111, 1'b0, 1'b0);
        chk_grant("arst_pre", 4'b0001, 1'b1, 0);
        step(4'b1111, 1'b0, 1'b0);
        #3;
        reset_ = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_valid", 32'(grant_valid), 32'd0);
        chk("arst_idx", 32'(grant_idx), 32'd0);
        #2;
        reset_ = 1'b1;
        model_reset();
        step(4'b1111, 1'b0, 1'b0);
        chk_grant("arst_post", 4'b0001, 1'b1, 0);

        // Long stall: grant holds, lane 3 saturates, then wins.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(4'b1001, 1'b0, 1'b0);
            chk($sformatf("stall%0d_grant", c), 32'(grant), 32'b0001);
        end
        chk("stall_age3", 32'(dut.age[3]), 32'd15);
        step(4'b1001, 1'b1, 1'b0);
        chk_grant("stall_next", 4'b1000, 1'b1, 3);

        // Age priority: equal ages resolve to the lower index.
        do_reset();
        for (int c = 0; c < 3; c++) step(4'b0001, 1'b0, 1'b0);
        chk_grant("prio_hold", 4'b0001, 1'b1, 0);
        step(4'b1011, 1'b0, 1'b0);
        step(4'b1011, 1'b1, 1'b0);
        chk_grant("prio_first", 4'b0010, 1'b1, 1);
        step(4'b1011, 1'b1, 1'b0);
        chk_grant("prio_second", 4'b1000, 1'b1, 3);

`ifdef AGE_ARB_LOCK_EN
        do_reset();
        step(4'b0011, 1'b1, 1'b1);
        chk_grant("lock0", 4'b0001, 1'b1, 0);
        for (int c = 0; c < 3; c++) begin
            step(4'b0011, 1'b1, 1'b1);
            chk_grant($sformatf("lock_hold%0d", c), 4'b0001, 1'b1, 0);
        end
        step(4'b0011, 1'b1, 1'b0);
        chk_grant("lock_release", 4'b0010, 1'b1, 1);
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [3:0] r;
            bit rdy;
            bit lk;
            r   = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
`ifdef AGE_ARB_LOCK_EN
            lk  = ($urandom_range(0, 2) == 0);
`else
            lk  = 1'b0;
`endif
            step(r, rdy, lk);
            chk("rand_valid", 32'(grant_valid), 32'(m_valid));
            chk("rand_grant", 32'(grant), m_valid ? (32'd1 << m_idx) : 32'd0);
            if (m_valid) chk("rand_idx", 32'(grant_idx), 32'(m_idx));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/age_arb.md
# age_arb

Age-based arbiter that shares a single downstream resource among `REQ` requesters. Each requester has a saturating wait-age counter. A `sel_minmax` instance in max mode picks the oldest active requester, and its result is registered as a one-hot grant held under a valid/ready handshake. The block sits in front of any shared port, such as a write port, bus master or functional unit, and sequences access to it.

## Interface
- `REQ`, 8, number of requesters (≥2)
- `AGE`, 4, age counter width in bits
- `ACT`, `` `HIGH ``, active polarity of the `req` and `grant` vectors
- `clk` in 1: clock, rising edge
- `reset_` in 1: reset, asynchronous, active-low
- `req` in `REQ`: per-lane request, polarity `ACT`
- `ready` in 1: resource accepts the current grant (active high)
- `grant` out `REQ`: one-hot grant, polarity `ACT`; all lanes DISABLE when no grant
- `grant_idx` out `$clog2(REQ)`: index of the granted lane
- `grant_valid` out 1: grant is being presented (active high)
- `lock` in 1: present only with `AGE_ARB_LOCK_EN`; see Configuration

## Operation
- **States.** IDLE (no grant presented) and GRANT (`grant_valid`=1).
- **Handshake.** A handshake occurs on a cycle with `grant_valid` && `ready`.
- **Selection key.** Each lane's key is {`req_active`, `age`}, `AGE`+1 bits wide, and the winner is the maximum key.
  - A non-requesting lane therefore never beats a requesting lane.
  - Equal keys resolve to the lowest index.
- **IDLE.**
  - If any request is active, the winner is registered and the state moves to GRANT.
  - Otherwise the block stays in IDLE.
- **GRANT, while `ready`=0.** `grant`, `grant_idx` and `grant_valid` hold stable, with no re-arbitration. A late, older request does not preempt the presented grant.
- **GRANT, on a handshake.**
  - The granted lane's age clears to 0.
  - A new winner is selected in the same cycle, with the just-granted lane masked out. If one exists, it is loaded and the state stays GRANT. Otherwise the state returns to IDLE.
- **Age update, every cycle.**
  - A lane that is requesting and not currently granted increments by 1.
  - Increment saturates at 2^`AGE`−1; it never wraps.
  - A lane with `req` inactive clears to 0.
  - The granted lane's age is frozen until its handshake.
- **Requester rule.** A requester must hold `req` until it is granted. If `req` drops while the lane is granted, the grant is not retracted; it completes on `ready`.
- **Invariant.** `grant` is always one-hot or all-DISABLE, and `grant[grant_idx]`=ENABLE whenever `grant_valid`=1.

## Timing
- **Reset values.** Asserting `reset_` low immediately forces:
  - `grant` all DISABLE, `grant_idx`=0, `grant_valid`=0;
  - all ages 0, state IDLE.
- **Reset mid-operation.** An in-flight grant is dropped, with no handshake credited.
- **First-grant latency.** A request first seen in IDLE at edge n produces `grant_valid` from edge n+1.
- **Back-to-back grants.** A handshake at edge n with another request pending gives the next grant valid from edge n+1, so throughput is one grant per cycle.
- **Sole repeated requester.** A lane that is the only requester and keeps requesting is granted every other cycle: GRANT, IDLE, GRANT, … This follows from the mask on the just-granted lane.
- **Outputs.** All outputs are registered; there is no combinational path from `req` or `ready` to the outputs.

## Configuration
- **`AGE_ARB_LOCK_EN` defined.**
  - The `lock` input exists.
  - If a handshake occurs with `lock`=1 and the granted lane's `req` is still active, the same lane is re-granted from the next cycle, bypassing age selection. Its age stays 0.
  - Other lanes keep aging (saturating).
  - The lock ends on the first handshake with `lock`=0.
- **Not defined.** There is no `lock` port, and the behaviour is identical to `lock` tied to 0.

## Test plan
All scenarios use `REQ`=4, `AGE`=4, `ACT`=`` `HIGH ``.
- **Reset.**
  - Stimulus: `req`=1111, `ready`=0 until GRANT is reached, then pulse `reset_` low asynchronously (between clock edges).
  - Response: `grant`=0000 and `grant_valid`=0 immediately; after release, the first grant is lane 0.
- **Single requester.**
  - Stimulus: `req`=0100, `ready`=1.
  - Response: `grant`=0100, `grant_idx`=2 and `grant_valid`=1 one cycle later. `grant_valid` then alternates 1,0,1,0.
- **Fair rotation.**
  - Stimulus: `req`=1111 from IDLE, `ready`=1.
  - Response: grants lane 0,1,2,3,0,… on consecutive cycles, with `grant_valid` continuously 1.
- **Stall and saturation.**
  - Stimulus: `req`=1001, `ready`=0 for 20 cycles.
  - Response: `grant` stays 0001 throughout and lane 3's age saturates at 15.
  - Then set `ready`=1: the next grant is lane 3.
- **Age priority.**
  - Stimulus: `req`=0001 held with `ready`=0 for 3 cycles, then `req`=1011, then `ready`=1.
  - Response: lanes 1 and 3 tie on age, so after lane 0's handshake the next grant is lane 1 (lower index), then lane 3.
- **Lock (with `AGE_ARB_LOCK_EN` only).**
  - Stimulus: `req`=0011, `ready`=1, `lock`=1 during lane 0's grants.
  - Response: lane 0 is re-granted each cycle.
  - Then drop `lock` to 0: the next grant is lane 1.
